// File: rtl/fm_eth_pkg.sv
// Shared constants, FSM state type and word-packing helper for the FM sample feeder.
package fm_eth_pkg;

    localparam logic MODE_IQ    = 1'b0;
    localparam logic MODE_AUDIO = 1'b1;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned SMP_W      = 16;
    localparam int unsigned SEQ_W      = 8;
    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } out_state_e;

    // Audio words carry a sequence byte so the MAC side can spot gaps.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic             mode,
        input logic [SEQ_W-1:0] seq,
        input logic [SMP_W-1:0] smp_i,
        input logic [SMP_W-1:0] smp_q
    );
        logic [WORD_W-1:0] word;
        if (mode == MODE_AUDIO) begin
            word = {seq, smp_i, smp_q[SMP_W-1:SEQ_W]};
        end else begin
            word = {smp_i, smp_q};
        end
        return word;
    endfunction

endpackage

// File: rtl/fm_eth_sample_feeder_fifo.sv
// Single-clock first-word-fall-through word FIFO with registered occupancy.
module fm_word_fifo
    import fm_eth_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WORD_W-1:0]        din,
    output logic [WORD_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit separates the wrapped-full case from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; the read side only consumes written entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fm_eth_sample_feeder.sv
// Packs FM samples into words, queues them and replays each as a paced strobe/data pair.
module fm_eth_sample_feeder
    import fm_eth_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned HIGH_CYC   = 8,
    parameter int unsigned LOW_CYC    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode_i,
    input  logic                          smp_valid_i,
    input  logic [SMP_W-1:0]              smp_i_i,
    input  logic [SMP_W-1:0]              smp_q_i,
    output logic                          fm_clk_o,
    output logic [WORD_W-1:0]             fm_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic [DROP_CNT_W-1:0]         drop_cnt_o,
    input  logic                          clr_stats_i
);

    localparam int unsigned MAX_SH  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
    localparam int unsigned MAX_CYC = (MAX_SH > LOW_CYC) ? MAX_SH : LOW_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    out_state_e         state;
    logic [CNT_W-1:0]   phase_cnt;
    logic [SEQ_W-1:0]   seq;

    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_dout;
    logic [WORD_W-1:0]  push_word;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // A full FIFO still accepts a sample when the output side frees a slot that cycle.
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign push_ok   = smp_valid_i && (!fifo_full || pop);
    assign drop      = smp_valid_i && !push_ok;
    assign push_word = pack_word(mode_i, seq, smp_i_i, smp_q_i);

    fm_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .din   (push_word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    // Audio sequence number advances only for samples that were actually queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
        end else if (push_ok && (mode_i == MODE_AUDIO)) begin
            seq <= seq + SEQ_W'(1);
        end
    end

    // Clear beats a same-cycle drop, which then restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clr_stats_i) begin
            overflow_o <= drop;
            drop_cnt_o <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
            end
        end
    end

    // Output pacer: one down-counter reloaded with N-1 on entry to each timed phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            fm_clk_o  <= 1'b0;
            fm_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fm_clk_o <= 1'b0;
                    if (!fifo_empty) begin
                        fm_data_o <= fifo_dout;
                        phase_cnt <= CNT_W'(SETUP_CYC - 1);
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_cnt == '0) begin
                        fm_clk_o  <= 1'b1;
                        phase_cnt <= CNT_W'(HIGH_CYC - 1);
                        state     <= ST_HIGH;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (phase_cnt == '0) begin
                        fm_clk_o  <= 1'b0;
                        phase_cnt <= CNT_W'(LOW_CYC - 1);
                        state     <= ST_LOW;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (phase_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    fm_clk_o <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_eth_sample_feeder.sv
// Self-checking bench: queue-based timing model of the feeder plus directed scenarios.
module tb_fm_eth_sample_feeder;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned S      = 4;
    localparam int unsigned H      = 8;
    localparam int unsigned L      = 8;
    localparam int          PERIOD = 1 + S + H + L;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_i = 1'b0;
    logic        smp_valid_i = 1'b0;
    logic [15:0] smp_i_i = '0;
    logic [15:0] smp_q_i = '0;
    logic        clr_stats_i = 1'b0;
    logic        fm_clk_o;
    logic [31:0] fm_data_o;
    logic [4:0]  fifo_level_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    always #5 clk = ~clk;

    fm_eth_sample_feeder #(
        .FIFO_DEPTH (DEPTH),
        .SETUP_CYC  (S),
        .HIGH_CYC   (H),
        .LOW_CYC    (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode_i),
        .smp_valid_i  (smp_valid_i),
        .smp_i_i      (smp_i_i),
        .smp_q_i      (smp_q_i),
        .fm_clk_o     (fm_clk_o),
        .fm_data_o    (fm_data_o),
        .fifo_level_o (fifo_level_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o),
        .clr_stats_i  (clr_stats_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a word queue, the edge at which the current word was
    // presented, and plain counters for sequence and drop statistics.
    logic [31:0] mq[$];
    int          edge_n;
    int          emit_edge;
    bit          emitting;
    logic [31:0] m_data;
    logic [7:0]  m_seq;
    bit          m_ovf;
    int unsigned m_drops;
    bit          m_popped;

    function automatic void m_reset();
        mq.delete();
        edge_n    = 0;
        emit_edge = 0;
        emitting  = 0;
        m_data    = '0;
        m_seq     = '0;
        m_ovf     = 0;
        m_drops   = 0;
        m_popped  = 0;
    endfunction

    // True when the output side takes a word at the coming edge.
    function automatic bit m_pop_next();
        return (!emitting || ((edge_n + 1 - emit_edge) >= PERIOD)) && (mq.size() > 0);
    endfunction

    task automatic check_outputs();
        int  d;
        bit  clk_exp;
        d       = edge_n - emit_edge;
        clk_exp = emitting && (d >= int'(S)) && (d < int'(S + H));
        check_eq("fm_clk", 32'(fm_clk_o), 32'(clk_exp));
        check_eq("fm_data", fm_data_o, m_data);
        check_eq("level", 32'(fifo_level_o), 32'(mq.size()));
        check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
        check_eq("drop_cnt", 32'(drop_cnt_o), (m_drops > 32'hFFFF) ? 32'hFFFF : 32'(m_drops));
    endtask

    task automatic step(input bit v, input bit m, input logic [15:0] si, input logic [15:0] sq,
                        input bit clr);
        bit          pop;
        bit          acc;
        bit          drop;
        logic [31:0] w;
        smp_valid_i = v;
        mode_i      = m;
        smp_i_i     = si;
        smp_q_i     = sq;
        clr_stats_i = clr;
        @(posedge clk);
        pop  = m_pop_next();
        acc  = v && ((mq.size() < int'(DEPTH)) || pop);
        drop = v && !acc;
        w    = m ? {m_seq, si, sq[15:8]} : {si, sq};
        edge_n++;
        m_popped = pop;
        if (pop) begin
            m_data    = mq.pop_front();
            emitting  = 1;
            emit_edge = edge_n;
        end
        if (acc) begin
            mq.push_back(w);
            if (m) m_seq++;
        end
        if (clr) begin
            m_ovf   = drop;
            m_drops = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1;
            m_drops++;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        smp_valid_i = 1'b0;
        clr_stats_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        int          t;
        int          nword;
        int          pushes;
        int          n;
        logic [4:0]  peak;
        bit          any_high;
        bit          rnd_v;

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_clk", 32'(fm_clk_o), 0);
        check_eq("rst_data", fm_data_o, 0);
        check_eq("rst_level", 32'(fifo_level_o), 0);
        check_eq("rst_ovf", 32'(overflow_o), 0);
        check_eq("rst_drop", 32'(drop_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // IQ single sample: fixed latency and strobe shape
        step(1, 0, 16'h1234, 16'hABCD, 0);
        check_eq("iq_data_before", fm_data_o, 0);
        step(0, 0, '0, '0, 0);
        check_eq("iq_data", fm_data_o, 32'h1234ABCD);
        for (int k = 1; k <= int'(S + H + L); k++) begin
            step(0, 0, '0, '0, 0);
            check_eq("iq_clk_shape", 32'(fm_clk_o), 32'((k >= int'(S)) && (k < int'(S + H))));
        end
        idle(3);

        // Audio sequence: three pushes, words 21 cycles apart, then seq wrap
        do_reset();
        for (t = 1; t <= 46; t++) begin
            step(t <= 3, 1, 16'hAABB, 16'hCC00, 0);
            if (t == 2)  check_eq("aud_w0", fm_data_o, 32'h00AABBCC);
            if (t == 22) check_eq("aud_w0_hold", fm_data_o, 32'h00AABBCC);
            if (t == 23) check_eq("aud_w1", fm_data_o, 32'h01AABBCC);
            if (t == 44) check_eq("aud_w2", fm_data_o, 32'h02AABBCC);
        end
        nword  = 3;
        pushes = 3;
        n      = 0;
        while ((nword < 258) && (n < 8000)) begin
            rnd_v = (pushes < 300) && (mq.size() < int'(DEPTH));
            step(rnd_v, 1, 16'($urandom), 16'($urandom), 0);
            if (rnd_v) pushes++;
            if (m_popped) begin
                nword++;
                if (nword == 256) check_eq("seq_ff", 32'(fm_data_o[31:24]), 32'hFF);
                if (nword == 257) check_eq("seq_wrap", 32'(fm_data_o[31:24]), 32'h00);
            end
            n++;
        end
        check_eq("seq_wrap_reached", 32'(nword >= 258), 1);

        // Overflow burst into a busy pacer
        do_reset();
        peak = '0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 16'($urandom), 16'($urandom), 0);
            if (fifo_level_o > peak) peak = fifo_level_o;
        end
        check_eq("ovf_peak", 32'(peak), 16);
        check_eq("ovf_flag", 32'(overflow_o), 1);
        check_eq("ovf_drops", 32'(drop_cnt_o), 3);
        step(0, 0, '0, '0, 1);
        check_eq("clr_flag", 32'(overflow_o), 0);
        check_eq("clr_drops", 32'(drop_cnt_o), 0);

        // Full FIFO, push on the pop cycle
        n = 0;
        while (!m_pop_next() && (n < 40)) begin
            step(0, 0, '0, '0, 0);
            n++;
        end
        check_eq("full_before", 32'(fifo_level_o), 16);
        step(1, 0, 16'h5A5A, 16'hC3C3, 0);
        check_eq("full_pushpop_level", 32'(fifo_level_o), 16);
        check_eq("full_pushpop_drops", 32'(drop_cnt_o), 0);
        check_eq("full_pushpop_ovf", 32'(overflow_o), 0);

        // Asynchronous reset while the strobe is high
        n = 0;
        while ((fm_clk_o !== 1'b1) && (n < 60)) begin
            step(0, 0, '0, '0, 0);
            n++;
        end
        check_eq("wait_high", 32'(fm_clk_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_clk", 32'(fm_clk_o), 0);
        check_eq("arst_data", fm_data_o, 0);
        check_eq("arst_level", 32'(fifo_level_o), 0);
        check_eq("arst_ovf", 32'(overflow_o), 0);
        @(negedge clk);
        m_reset();
        rst_n    = 1'b1;
        any_high = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 0, '0, '0, 0);
            if (fm_clk_o) any_high = 1;
        end
        check_eq("no_emit_after_rst", 32'(any_high), 0);

        // Randomized traffic: light load, heavy load, random clears and modes
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rnd_v = (i < 1500) ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) == 0);
            step(rnd_v, 1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 63) == 0);
        end
        idle(DEPTH * PERIOD + 5);

        // Drop counter saturation
        do_reset();
        n = 0;
        while ((m_drops < 65540) && (n < 80000)) begin
            step(1, 0, 16'($urandom), 16'($urandom), 0);
            n++;
        end
        check_eq("sat_cnt", 32'(drop_cnt_o), 32'hFFFF);
        check_eq("sat_ovf", 32'(overflow_o), 1);
        step(1, 0, 16'($urandom), 16'($urandom), 1);
        step(0, 0, '0, '0, 1);
        check_eq("sat_clr", 32'(drop_cnt_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
